// File: rtl/riscv_muldiv_pkg.sv
// Shared M-extension encodings and the issue-controller state encoding.
package riscv_muldiv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } md_state_t;

endpackage

// File: rtl/muldiv_special_case.sv
// Divide-by-zero and signed-overflow divides, resolved without the iterative unit.
module muldiv_special_case
    import riscv_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            is_special,
    output logic [XLEN-1:0] special_result
);

    logic is_div, is_rem, is_signed, b_zero, ovf;

    assign is_div    = funct3[2];
    assign is_rem    = funct3[1];
    assign is_signed = ~funct3[0];
    assign b_zero    = (b == '0);
    assign ovf       = is_signed & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);

    assign is_special = is_div & (b_zero | ovf);

    // Divide-by-zero takes precedence; the overflow operands never have b==0.
    always_comb begin
        special_result = '0;
        if (b_zero)
            special_result = is_rem ? a : '1;
        else if (ovf)
            special_result = is_rem ? '0 : a;
    end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// EX-stage sequencer for the iterative multiply/divide unit: issue, stall, capture, retire.
module muldiv_issue_ctrl
    import riscv_muldiv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_is_muldiv,
    input  logic [2:0]      ex_funct3,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_rs1_val,
    input  logic [XLEN-1:0] ex_rs2_val,
    input  logic            flush,
    input  logic            md_busy,
    input  logic            md_ready,
    input  logic [XLEN-1:0] md_result,
    output logic            md_start,
    output logic [2:0]      md_op,
    output logic [XLEN-1:0] md_a,
    output logic [XLEN-1:0] md_b,
    output logic            stall_req,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      result_rd,
    output logic            err_timeout
);

    localparam int CW = $clog2(TIMEOUT);

    md_state_t       state, state_nxt;
    logic [CW-1:0]   wait_cnt;
    logic            req, cnt_max, is_special;
    logic [XLEN-1:0] special_result;

    assign req     = ex_valid & ex_is_muldiv & ~flush;
    assign cnt_max = (wait_cnt == CW'(TIMEOUT-1));

    muldiv_special_case #(.XLEN(XLEN)) u_special (
        .funct3         (ex_funct3),
        .a              (ex_rs1_val),
        .b              (ex_rs2_val),
        .is_special     (is_special),
        .special_result (special_result)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req) state_nxt = is_special ? S_DONE : S_ISSUE;
            S_ISSUE: state_nxt = flush ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (flush)                    state_nxt = S_DRAIN;
                else if (md_ready || cnt_max) state_nxt = S_DONE;
            end
            S_DRAIN: if (md_ready || !md_busy) state_nxt = S_IDLE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign md_start     = (state == S_ISSUE);
    assign result_valid = (state == S_DONE);
    // Gated by rst so an asynchronous abort drops the stall in the same cycle.
    assign stall_req    = ~rst & (((state == S_IDLE) & req) | (state == S_ISSUE) |
                                  (state == S_WAIT) | (state == S_DRAIN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            md_op       <= '0;
            md_a        <= '0;
            md_b        <= '0;
            result      <= '0;
            result_rd   <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (req) begin
                    md_op     <= ex_funct3;
                    md_a      <= ex_rs1_val;
                    md_b      <= ex_rs2_val;
                    result_rd <= ex_rd;
                    if (is_special) result <= special_result;
                end
                S_ISSUE: wait_cnt <= '0;
                S_WAIT: if (!flush) begin
                    if (md_ready) begin
                        result <= md_result;
                    end else if (cnt_max) begin
                        result      <= '0;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl with a small behavioural multiply unit of configurable latency.
module tb_muldiv_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0, ex_is_muldiv = 1'b0, flush = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [4:0]  ex_rd = '0;
    logic [31:0] ex_rs1_val = '0, ex_rs2_val = '0;
    logic        md_busy, md_ready;
    logic [31:0] md_result;
    logic        md_start, stall_req, result_valid, err_timeout;
    logic [2:0]  md_op;
    logic [31:0] md_a, md_b, result;
    logic [4:0]  result_rd;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    muldiv_issue_ctrl #(.XLEN(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_is_muldiv(ex_is_muldiv), .ex_funct3(ex_funct3),
        .ex_rd(ex_rd), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .flush(flush), .md_busy(md_busy), .md_ready(md_ready), .md_result(md_result),
        .md_start(md_start), .md_op(md_op), .md_a(md_a), .md_b(md_b),
        .stall_req(stall_req), .result_valid(result_valid), .result(result),
        .result_rd(result_rd), .err_timeout(err_timeout)
    );

    // Unit model: md_ready pulses lat cycles after the md_start cycle; hang keeps it busy forever.
    int          lat = 3;
    logic        hang = 1'b0;
    logic        u_busy;
    int          u_cnt;
    logic [31:0] u_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            u_busy <= 1'b0;
            u_cnt  <= 0;
            u_res  <= '0;
        end else if (md_start) begin
            u_busy <= 1'b1;
            u_cnt  <= lat - 1;
            u_res  <= md_a * md_b;
        end else if (u_busy && !hang) begin
            if (u_cnt == 0) u_busy <= 1'b0;
            else            u_cnt  <= u_cnt - 1;
        end
    end

    assign md_busy   = u_busy;
    assign md_ready  = u_busy && !hang && (u_cnt == 0);
    assign md_result = u_res;

    task automatic drive(input logic v, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input logic fl);
        ex_valid     = v;
        ex_is_muldiv = v;
        ex_funct3    = f3;
        ex_rd        = rd;
        ex_rs1_val   = a;
        ex_rs2_val   = b;
        flush        = fl;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        tests++;
        if ({md_start, stall_req, result_valid, err_timeout} !== 4'b0) begin
            fails++; $display("FAIL reset_ctl: got %b want 0000", {md_start, stall_req, result_valid, err_timeout});
        end
        tests++;
        if ({md_op, md_a, md_b, result, result_rd} !== '0) begin
            fails++; $display("FAIL reset_data: got op=%h a=%h b=%h res=%h rd=%h want 0", md_op, md_a, md_b, result, result_rd);
        end
        rst = 1'b0;
    endtask

    // MUL 6*4 rd=3, L=3: start at 1, stall 0..4, result_valid at 5.
    task automatic test_mul();
        logic e;
        lat = 3;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c <= 5) drive(1, 3'b000, 5'd3, 32'd6, 32'd4, 0);
            else        drive(0, 3'b000, 5'd0, 32'd0, 32'd0, 0);
            #1;
            e = (c == 1);
            tests++; if (md_start !== e) begin fails++; $display("FAIL mul_start c=%0d: got %b want %b", c, md_start, e); end
            e = (c <= 4);
            tests++; if (stall_req !== e) begin fails++; $display("FAIL mul_stall c=%0d: got %b want %b", c, stall_req, e); end
            e = (c == 5);
            tests++; if (result_valid !== e) begin fails++; $display("FAIL mul_rv c=%0d: got %b want %b", c, result_valid, e); end
            if (c == 5) begin
                tests++; if (result !== 32'h18) begin fails++; $display("FAIL mul_result: got %h want 00000018", result); end
                tests++; if (result_rd !== 5'd3) begin fails++; $display("FAIL mul_rd: got %0d want 3", result_rd); end
            end
        end
    endtask

    // Divide-by-zero and signed overflow: one stall cycle, result next cycle, no md_start.
    task automatic test_special_cases();
        logic [2:0]  f3 [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
        logic [31:0] a  [4] = '{32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex [4] = '{32'hFFFF_FFFF, 32'h0000_0007, 32'h8000_0000, 32'h0000_0000};
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (c <= 1) drive(1, f3[i], 5'd10 + 5'(i), a[i], b[i], 0);
                else        drive(0, 3'b000, 5'd0, 32'd0, 32'd0, 0);
                #1;
                tests++; if (md_start !== 1'b0) begin fails++; $display("FAIL spec%0d_start c=%0d: got %b want 0", i, c, md_start); end
                tests++; if (stall_req !== (c == 0)) begin fails++; $display("FAIL spec%0d_stall c=%0d: got %b", i, c, stall_req); end
                tests++; if (result_valid !== (c == 1)) begin fails++; $display("FAIL spec%0d_rv c=%0d: got %b", i, c, result_valid); end
                if (c == 1) begin
                    tests++; if (result !== ex[i]) begin fails++; $display("FAIL spec%0d_result: got %h want %h", i, result, ex[i]); end
                    tests++; if (result_rd !== 5'd10 + 5'(i)) begin fails++; $display("FAIL spec%0d_rd: got %0d want %0d", i, result_rd, 10 + i); end
                end
            end
        end
    endtask

    // Flush in WAIT: drain discards the unit result; the next MUL waits out the drain.
    task automatic test_flush_drain();
        logic e;
        lat = 6;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c <= 2)       drive(1, 3'b000, 5'd5, 32'd2, 32'd9, 0);
            else if (c == 3)  drive(1, 3'b000, 5'd5, 32'd2, 32'd9, 1);
            else if (c <= 13) begin drive(1, 3'b000, 5'd7, 32'd3, 32'd5, 0); lat = 3; end
            else              drive(0, 3'b000, 5'd0, 32'd0, 32'd0, 0);
            #1;
            e = (c == 1) || (c == 9);
            tests++; if (md_start !== e) begin fails++; $display("FAIL flush_start c=%0d: got %b want %b", c, md_start, e); end
            e = (c <= 12);
            tests++; if (stall_req !== e) begin fails++; $display("FAIL flush_stall c=%0d: got %b want %b", c, stall_req, e); end
            e = (c == 13);
            tests++; if (result_valid !== e) begin fails++; $display("FAIL flush_rv c=%0d: got %b want %b", c, result_valid, e); end
            if (c == 8) begin
                tests++; if (result !== 32'h0) begin fails++; $display("FAIL flush_discard: got %h want 00000000", result); end
            end
            if (c == 13) begin
                tests++; if (result !== 32'h0F) begin fails++; $display("FAIL flush_result: got %h want 0000000f", result); end
                tests++; if (result_rd !== 5'd7) begin fails++; $display("FAIL flush_rd: got %0d want 7", result_rd); end
            end
        end
    endtask

    // MUL then DIVU-by-zero presented the cycle after DONE.
    task automatic test_back_to_back();
        logic e;
        lat = 3;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c <= 5)      drive(1, 3'b000, 5'd3, 32'd6, 32'd4, 0);
            else if (c <= 7) drive(1, 3'b101, 5'd9, 32'd100, 32'd0, 0);
            else             drive(0, 3'b000, 5'd0, 32'd0, 32'd0, 0);
            #1;
            e = (c == 1);
            tests++; if (md_start !== e) begin fails++; $display("FAIL b2b_start c=%0d: got %b want %b", c, md_start, e); end
            e = (c <= 4) || (c == 6);
            tests++; if (stall_req !== e) begin fails++; $display("FAIL b2b_stall c=%0d: got %b want %b", c, stall_req, e); end
            e = (c == 5) || (c == 7);
            tests++; if (result_valid !== e) begin fails++; $display("FAIL b2b_rv c=%0d: got %b want %b", c, result_valid, e); end
            if (c == 5) begin
                tests++; if (result !== 32'h18 || result_rd !== 5'd3) begin fails++; $display("FAIL b2b_first: got %h rd=%0d want 00000018 rd=3", result, result_rd); end
            end
            if (c == 7) begin
                tests++; if (result !== 32'hFFFF_FFFF || result_rd !== 5'd9) begin fails++; $display("FAIL b2b_second: got %h rd=%0d want ffffffff rd=9", result, result_rd); end
            end
        end
    endtask

    // Unit never answers: WAIT spans cycles 2..65, forced completion at 66 with result 0.
    task automatic test_timeout();
        logic e;
        hang = 1'b1;
        for (int c = 0; c < 71; c++) begin
            @(negedge clk);
            if (c <= 66) drive(1, 3'b000, 5'd1, 32'd2, 32'd2, 0);
            else         drive(0, 3'b000, 5'd0, 32'd0, 32'd0, 0);
            #1;
            e = (c == 1);
            tests++; if (md_start !== e) begin fails++; $display("FAIL to_start c=%0d: got %b want %b", c, md_start, e); end
            e = (c <= 65);
            tests++; if (stall_req !== e) begin fails++; $display("FAIL to_stall c=%0d: got %b want %b", c, stall_req, e); end
            e = (c == 66);
            tests++; if (result_valid !== e) begin fails++; $display("FAIL to_rv c=%0d: got %b want %b", c, result_valid, e); end
            e = (c >= 66);
            tests++; if (err_timeout !== e) begin fails++; $display("FAIL to_err c=%0d: got %b want %b", c, err_timeout, e); end
            if (c == 66) begin
                tests++; if (result !== 32'h0) begin fails++; $display("FAIL to_result: got %h want 00000000", result); end
            end
        end
    endtask

    // Async reset in WAIT clears everything at once; a fresh MUL then runs normally.
    task automatic test_reset_mid_wait();
        logic e;
        hang = 1'b0;
        lat  = 3;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1, 3'b000, 5'd3, 32'd6, 32'd4, 0);
        end
        #1;
        tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL rstw_pre_stall: got %b want 1", stall_req); end
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({md_start, stall_req, result_valid, err_timeout} !== 4'b0) begin
            fails++; $display("FAIL rstw_ctl: got %b want 0000", {md_start, stall_req, result_valid, err_timeout});
        end
        tests++;
        if ({md_op, md_a, md_b, result, result_rd} !== '0) begin
            fails++; $display("FAIL rstw_data: got op=%h a=%h b=%h res=%h rd=%h want 0", md_op, md_a, md_b, result, result_rd);
        end
        @(negedge clk);
        drive(0, 3'b000, 5'd0, 32'd0, 32'd0, 0);
        rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c <= 5) drive(1, 3'b000, 5'd3, 32'd6, 32'd4, 0);
            else        drive(0, 3'b000, 5'd0, 32'd0, 32'd0, 0);
            #1;
            e = (c == 1);
            tests++; if (md_start !== e) begin fails++; $display("FAIL rstw_start c=%0d: got %b want %b", c, md_start, e); end
            e = (c == 5);
            tests++; if (result_valid !== e) begin fails++; $display("FAIL rstw_rv c=%0d: got %b want %b", c, result_valid, e); end
            if (c == 5) begin
                tests++; if (result !== 32'h18) begin fails++; $display("FAIL rstw_result: got %h want 00000018", result); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_special_cases();
        test_flush_drain();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
